aes_round_sequencer: RTL
========================

// Module: aes_round_sequencer
// PURPOSE
// - Parametrised successor to the single-key-size AES controller.
// - Sequences key expansion and the per-round stage engines (sub bytes, shift rows, mix columns, add round key)
//   for AES-128/192/256, in both encrypt and decrypt order.
// - Sits between the AHB slave front end (start/invalid) and the stage datapath modules (enable/finished pairs).
// - Retains the expanded key across blocks, so key expansion reruns only when a new key is loaded.
// PARAMETERS
// - KEY_BITS   128  AES key size: 128/192/256; sets NR = 10/12/14. Any other value is a compile-time $error.
// - WD_CYCLES  64   Watchdog limit in cycles per stage (used only with the watchdog macro).
// PORTS
// - clk              in   1  Clock, rising edge.
// - rst              in   1  Asynchronous, active-high reset.
// - start            in   1  Single-cycle request to process one block.
// - decrypt          in   1  Sampled with start: 0 = encrypt, 1 = decrypt.
// - key_new          in   1  Sampled with start: key register changed, force key expansion.
// - invalid          in   1  Front-end abort request.
// - keyexp_finished  in   1  Stage completion input (level or pulse).
// - sbytes_finished  in   1  Stage completion input (level or pulse).
// - srows_finished   in   1  Stage completion input (level or pulse).
// - mcol_finished    in   1  Stage completion input (level or pulse).
// - around_finished  in   1  Stage completion input (level or pulse).
// - keyexp_enable    out  1  Stage enable, level.
// - sbytes_enable    out  1  Stage enable, level.
// - srows_enable     out  1  Stage enable, level.
// - mcol_enable      out  1  Stage enable, level.
// - around_enable    out  1  Stage enable, level.
// - inverse          out  1  Selects inverse transforms in the stage engines; equals the latched decrypt bit.
// - roundnum         out  4  Round-key index presented to add-round-key.
// - busy             out  1  High in every state except IDLE.
// - done             out  1  One-cycle pulse when the block completes.
// - hresp_error      out  1  One-cycle error pulse: start while busy, abort, or watchdog expiry.
// BEHAVIOUR
// - Reset: state=IDLE, key_valid=0, roundnum=0, all outputs 0.
// - States: IDLE, KEYEXP, ARK0, SB, SR, MC, ARK, DONE.
//   - Exactly one stage enable is high per state: KEYEXP->keyexp; SB->sbytes; SR->srows; MC->mcol; ARK0/ARK->around.
//   - The enable is held high for the whole state.
// - Stage handshake: finished is ignored in the first cycle of a state, so a stale level from the previous stage
//   cannot advance it. From the 2nd cycle, the first cycle with finished=1 advances the state at the next edge.
//   Minimum stage latency is therefore 2 cycles.
// - IDLE + start:
//   - Latches decrypt into inverse.
//   - Goes to KEYEXP if key_new or !key_valid, otherwise straight to ARK0.
//   - KEYEXP completion sets key_valid=1.
// - Encrypt order:
//   - ARK0 with roundnum=0.
//   - Then for r = 1..NR: SB, SR, MC, ARK, with roundnum=r. MC is skipped when r==NR.
// - Decrypt order:
//   - ARK0 with roundnum=NR.
//   - Then for r = NR-1 down to 0: SR, SB, ARK, MC, with roundnum=r and inverse shift rows / sub bytes.
//   - MC is skipped when r==0.
// - roundnum changes only on entry to SB (encrypt) or SR (decrypt), i.e. once per round; it is held elsewhere.
// - DONE: done=1 for exactly one cycle, then IDLE. roundnum keeps its final value (NR or 0) until the next start.
// - start while busy: ignored, hresp_error pulses 1 cycle, operation continues.
// - invalid while busy: next state IDLE, all enables drop, hresp_error pulses.
//   - If aborted in KEYEXP, key_valid is cleared.
//   - invalid in IDLE has no effect.
// - invalid and finished in the same cycle: invalid wins.
// - Asynchronous rst mid-operation: immediate return to reset values, including key_valid=0.
// CONFIGURATION
// - AES_SEQ_WATCHDOG_EN defined:
//   - An 8-bit counter clears on every state entry and increments each cycle in a stage state.
//   - At WD_CYCLES without completion: abort exactly as for invalid (IDLE, hresp_error pulse, key_valid cleared
//     if in KEYEXP).
// - AES_SEQ_WATCHDOG_EN undefined: no counter; a stage may wait indefinitely. WD_CYCLES is unused.
// STRUCTURE
// - Package aes_pkg: state enum seq_state_t; function nr_of(KEY_BITS); constants AES128_NR=10, AES192_NR=12,
//   AES256_NR=14.
// - Sub-module aes_stage_timer: first-cycle mask plus the optional watchdog counter; outputs fin_ok and timeout.
// - Remaining logic in this module: FSM, round counter, key_valid flag.
// TESTING
// - KEY_BITS=128, encrypt, key_new=1, each finished returned 3 cycles after enable
//   -> sequence KEYEXP, ARK0(0), {SB,SR,MC,ARK}x9 (rounds 1..9), SB,SR,ARK(10); single done pulse.
// - Second start with key_new=0 -> no keyexp_enable; first enable is around_enable with roundnum=0.
// - KEY_BITS=256, decrypt -> ARK0 with roundnum=14, rounds 13..0 in SR,SB,ARK,MC order, no MC in round 0,
//   inverse=1 throughout.
// - around_finished held high across ARK0->SB and SB->SR boundaries -> each state still lasts >=2 cycles;
//   no state skipped.
// - start during SR of round 3 -> hresp_error 1 cycle, roundnum still 3, block completes normally.
// - invalid asserted in KEYEXP -> IDLE next cycle, key_valid=0, next start reruns KEYEXP.
//   With AES_SEQ_WATCHDOG_EN and WD_CYCLES=16, mcol_finished never asserted -> abort after 16 cycles in MC.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round sequencer: state encoding and
// round-count lookup per key size.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_ARK0,
    S_SB,
    S_SR,
    S_MC,
    S_ARK,
    S_DONE
  } seq_state_t;

  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;

  function automatic int nr_of(input int key_bits);
    case (key_bits)
      192:     return AES192_NR;
      256:     return AES256_NR;
      default: return AES128_NR;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle between the AHB front end / stage engines and the round sequencer.
// slave = sequencer side, master = environment side.
interface aes_round_sequencer_if;
  logic       start;
  logic       decrypt;
  logic       key_new;
  logic       invalid;
  logic       keyexp_finished;
  logic       sbytes_finished;
  logic       srows_finished;
  logic       mcol_finished;
  logic       around_finished;
  logic       keyexp_enable;
  logic       sbytes_enable;
  logic       srows_enable;
  logic       mcol_enable;
  logic       around_enable;
  logic       inverse;
  logic [3:0] roundnum;
  logic       busy;
  logic       done;
  logic       hresp_error;

  modport slave (
    input  start, decrypt, key_new, invalid,
    input  keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished,
    output keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable,
    output inverse, roundnum, busy, done, hresp_error
  );

  modport master (
    output start, decrypt, key_new, invalid,
    output keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished,
    input  keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable,
    input  inverse, roundnum, busy, done, hresp_error
  );
endinterface

// File: rtl/aes_stage_timer.sv
// First-cycle mask for stage completion plus optional per-stage watchdog.
// Watchdog counter present only when AES_SEQ_WATCHDOG_EN is defined.
module aes_stage_timer #(
  parameter int WD_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic stage,
  output logic fin_ok,
  output logic timeout
);

  if (WD_CYCLES < 1 || WD_CYCLES > 256) begin : g_bad_wd
    $error("aes_stage_timer: WD_CYCLES must be in 1..256");
  end

  logic first_q, first_d;

  // first_q marks the first cycle of any state, masking stale finished levels
  assign first_d = enter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) first_q <= 1'b0;
    else     first_q <= first_d;
  end

  assign fin_ok = stage & ~first_q;

`ifdef AES_SEQ_WATCHDOG_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enter)      cnt_d = '0;
    else if (stage) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q is 0 in the first cycle of a state, so this fires in cycle WD_CYCLES
  assign timeout = stage & (cnt_q == 8'(WD_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 round sequencer: key expansion and per-round stage engine control.
// Optional per-stage watchdog abort enabled by AES_SEQ_WATCHDOG_EN.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int KEY_BITS  = 128,
  parameter int WD_CYCLES = 64
) (
  input logic                   clk,
  input logic                   rst,
  aes_round_sequencer_if.slave  bus
);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_round_sequencer: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [3:0] NR = 4'(nr_of(KEY_BITS));

  seq_state_t state_q, state_d;
  logic       inverse_q, inverse_d;
  logic [3:0] roundnum_q, roundnum_d;
  logic       key_valid_q, key_valid_d;
  logic       err_q, err_d;
  logic       stage, fin_sel, fin_ok, timeout, adv, abort, enter;

  assign stage = (state_q != S_IDLE) && (state_q != S_DONE);
  assign enter = (state_d != state_q);

  aes_stage_timer #(.WD_CYCLES(WD_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enter   (enter),
    .stage   (stage),
    .fin_ok  (fin_ok),
    .timeout (timeout)
  );

  always_comb begin
    fin_sel = 1'b0;
    case (state_q)
      S_KEYEXP:     fin_sel = bus.keyexp_finished;
      S_SB:         fin_sel = bus.sbytes_finished;
      S_SR:         fin_sel = bus.srows_finished;
      S_MC:         fin_sel = bus.mcol_finished;
      S_ARK0, S_ARK: fin_sel = bus.around_finished;
      default:      fin_sel = 1'b0;
    endcase
  end

  assign adv   = fin_ok & fin_sel;
  // invalid beats a same-cycle finish; a finish in the last watchdog cycle beats the timeout
  assign abort = (state_q != S_IDLE) & (bus.invalid | (timeout & ~adv));

  always_comb begin
    state_d     = state_q;
    inverse_d   = inverse_q;
    roundnum_d  = roundnum_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      if (state_q == S_KEYEXP) key_valid_d = 1'b0;
    end else begin
      if (state_q != S_IDLE && bus.start) err_d = 1'b1;
      case (state_q)
        S_IDLE: if (bus.start) begin
          inverse_d  = bus.decrypt;
          roundnum_d = bus.decrypt ? NR : 4'd0;
          state_d    = (bus.key_new || !key_valid_q) ? S_KEYEXP : S_ARK0;
        end
        S_KEYEXP: if (adv) begin
          key_valid_d = 1'b1;
          state_d     = S_ARK0;
        end
        S_ARK0: if (adv) begin
          state_d    = inverse_q ? S_SR : S_SB;
          roundnum_d = inverse_q ? roundnum_q - 4'd1 : roundnum_q + 4'd1;
        end
        S_SB: if (adv) state_d = inverse_q ? S_ARK : S_SR;
        S_SR: if (adv) begin
          if (inverse_q)              state_d = S_SB;
          else if (roundnum_q == NR)  state_d = S_ARK;
          else                        state_d = S_MC;
        end
        S_MC: if (adv) begin
          if (inverse_q) begin
            state_d    = S_SR;
            roundnum_d = roundnum_q - 4'd1;
          end else begin
            state_d    = S_ARK;
          end
        end
        S_ARK: if (adv) begin
          if (inverse_q) begin
            state_d = (roundnum_q == 4'd0) ? S_DONE : S_MC;
          end else if (roundnum_q == NR) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_SB;
            roundnum_d = roundnum_q + 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inverse_q   <= 1'b0;
      roundnum_q  <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inverse_q   <= inverse_d;
      roundnum_q  <= roundnum_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.keyexp_enable = (state_q == S_KEYEXP);
  assign bus.sbytes_enable = (state_q == S_SB);
  assign bus.srows_enable  = (state_q == S_SR);
  assign bus.mcol_enable   = (state_q == S_MC);
  assign bus.around_enable = (state_q == S_ARK0) || (state_q == S_ARK);
  assign bus.inverse       = inverse_q;
  assign bus.roundnum      = roundnum_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.hresp_error   = err_q;

endmodule
